fft_bfly_addr_sched: RTL and testbench

//  Sequences one radix-2 in-place FFT stage. Issues one butterfly per cycle:

---
 rtl/fft_bfly_addr_sched_pkg.sv | 28 ++
 rtl/fft_addr_delay_line.sv | 63 ++++++
 rtl/fft_bfly_addr_sched.sv | 211 +++++++++++++++++++++
 tb/tb_fft_bfly_addr_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bfly_addr_sched_pkg.sv
// Shared FFT sequencing definitions: FSM encoding, stage-field width, twiddle sizing helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_bfly_addr_sched_pkg;

  // Width of stage_level / stage_number fields from the network controller
  localparam int STAGE_W = 4;

  // Stage sequencer FSM encoding
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  // Twiddle index covers 0..N/2-1, so it is one bit narrower than a data address
  function automatic int tw_width(input int addr_width);
    return addr_width - 1;
  endfunction

  // A stage request is runnable only if N fits the RAM and the stage exists in an N-point FFT
  function automatic logic cfg_valid(input logic [STAGE_W-1:0] s,
                                     input logic [STAGE_W-1:0] l,
                                     input int                 addr_width);
    return (l != '0) && (int'(l) <= addr_width) && (s < l);
  endfunction

endpackage

// File: rtl/fft_addr_delay_line.sv
// Write-back address delay: {en, addr_a, addr_b} shifted through DEPTH register stages.
// Latency: exactly DEPTH cycles from input to output.
// Backpressure: none; shifts every cycle, sync flush clears every stage.
module fft_addr_delay_line #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic                  en_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic                  upstream_empty_o
);

  logic [DEPTH-1:0]      vld_q;
  logic [ADDR_WIDTH-1:0] a_q [DEPTH];
  logic [ADDR_WIDTH-1:0] b_q [DEPTH];

  // Shift register; flush drops everything in flight so an aborted stage never writes back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= en_i;
      a_q[0]   <= addr_a_i;
      b_q[0]   <= addr_b_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
    end
  end

  assign en_o     = vld_q[DEPTH-1];
  assign addr_a_o = a_q[DEPTH-1];
  assign addr_b_o = b_q[DEPTH-1];

  // True when nothing is queued behind the output stage: whatever is on en_o now is the final write
  generate
    if (DEPTH > 1) begin : g_multi
      assign upstream_empty_o = ~|vld_q[DEPTH-2:0];
    end else begin : g_single
      assign upstream_empty_o = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/fft_bfly_addr_sched.sv
// Radix-2 in-place FFT stage sequencer: one butterfly (A/B read + twiddle index) per cycle.
// Latency: first read 1 cycle after start; write-back = reads delayed PIPE_LAT; done 1 cycle after last write.
// Backpressure: none; issues back-to-back until the stage completes or abort flushes it.
module fft_bfly_addr_sched
  import fft_bfly_addr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int PIPE_LAT   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STAGE_W-1:0]    stage_level,
  input  logic [STAGE_W-1:0]    stage_number,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-2:0] tw_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr_a,
  output logic [ADDR_WIDTH-1:0] wr_addr_b
);

  localparam int                    TW_W  = tw_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [STAGE_W-1:0]    ONE_S = STAGE_W'(1);

  // Sequencer state
  logic [STATE_W-1:0]    state_q,  state_d;
  logic [ADDR_WIDTH-1:0] k_q,      k_d;
  logic [ADDR_WIDTH-1:0] last_k_q, last_k_d;
  logic [STAGE_W-1:0]    s_q,      s_d;
  logic [STAGE_W-1:0]    l_q,      l_d;

  // Registered outputs
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  err_q,   err_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_a_q,  rd_a_d;
  logic [ADDR_WIDTH-1:0] rd_b_q,  rd_b_d;
  logic [TW_W-1:0]       tw_q,    tw_d;

  logic flush;
  logic cfg_ok;
  logic drain_done;

  // Address generator operands and results
  logic [STAGE_W-1:0]    s_use;
  logic [STAGE_W-1:0]    l_use;
  logic [ADDR_WIDTH-1:0] k_use;
  logic [ADDR_WIDTH-1:0] half;
  logic [ADDR_WIDTH-1:0] pos;
  logic [ADDR_WIDTH-1:0] grp;
  logic [ADDR_WIDTH-1:0] a_calc;
  logic [ADDR_WIDTH-1:0] b_calc;
  logic [TW_W-1:0]       tw_calc;

  assign cfg_ok = cfg_valid(stage_level, stage_number, ADDR_WIDTH);

  // Launch from IDLE uses the live config with k=0; afterwards the latched config and next k
  always_comb begin
    s_use = s_q;
    l_use = l_q;
    k_use = k_q + ONE_A;
    if (state_q == ST_IDLE) begin
      s_use = stage_level;
      l_use = stage_number;
      k_use = '0;
    end
  end

  // Butterfly k -> operand pair and twiddle; B differs from A only in bit s, so OR equals add
  always_comb begin
    half    = ONE_A << s_use;
    pos     = k_use & (half - ONE_A);
    grp     = k_use >> s_use;
    a_calc  = (grp << (s_use + ONE_S)) | pos;
    b_calc  = a_calc | half;
    tw_calc = pos[TW_W-1:0] << (l_use - s_use - ONE_S);
  end

  // Next-state and next-output logic; abort overrides everything except reset
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    last_k_d = last_k_q;
    s_d      = s_q;
    l_d      = l_q;
    rd_en_d  = 1'b0;
    rd_a_d   = '0;
    rd_b_d   = '0;
    tw_d     = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    flush    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      k_d     = '0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_d  = ST_ISSUE;
              s_d      = stage_level;
              l_d      = stage_number;
              last_k_d = (ONE_A << (stage_number - ONE_S)) - ONE_A;
              k_d      = '0;
              rd_en_d  = 1'b1;
              rd_a_d   = a_calc;
              rd_b_d   = b_calc;
              tw_d     = tw_calc;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // k_q is the butterfly currently on the read port
          if (k_q == last_k_q) begin
            state_d = ST_DRAIN;
          end else begin
            k_d     = k_use;
            rd_en_d = 1'b1;
            rd_a_d  = a_calc;
            rd_b_d  = b_calc;
            tw_d    = tw_calc;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // busy covers every non-IDLE cycle, including the done pulse
  assign busy_d = (state_d != ST_IDLE);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      last_k_q <= '0;
      s_q      <= '0;
      l_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      last_k_q <= last_k_d;
      s_q      <= s_d;
      l_q      <= l_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_en_q  <= rd_en_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      tw_q     <= tw_d;
    end
  end

  // Write-back addresses are the issued read addresses replayed after the butterfly pipeline
  fft_addr_delay_line #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (PIPE_LAT)
  ) u_wb_delay (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .en_i             (rd_en_q),
    .addr_a_i         (rd_a_q),
    .addr_b_i         (rd_b_q),
    .en_o             (wr_en),
    .addr_a_o         (wr_addr_a),
    .addr_b_o         (wr_addr_b),
    .upstream_empty_o (drain_done)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;

endmodule

// File: tb/tb_fft_bfly_addr_sched.sv
// Bench for fft_bfly_addr_sched: table of stage configs plus hand sequences for busy/abort/reset corners.
// Expected butterflies come from a group/position enumeration, queued at start and popped on rd_en/wr_en.
// All outputs are sampled on the falling clock edge.
module tb_fft_bfly_addr_sched;

  localparam int AW       = 12;
  localparam int PIPE_LAT = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [3:0]    stage_level;
  logic [3:0]    stage_number;
  logic          busy, done, err, rd_en, wr_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [AW-2:0] tw_addr;

  fft_bfly_addr_sched #(.ADDR_WIDTH(AW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .stage_level  (stage_level),
    .stage_number (stage_number),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rd_en        (rd_en),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .tw_addr      (tw_addr),
    .wr_en        (wr_en),
    .wr_addr_a    (wr_addr_a),
    .wr_addr_b    (wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int tw;
  } bfly_t;

  typedef struct {
    int l;
    int s;
    bit exp_err;
    int last_a;
    int last_b;
    int last_tw;
    int done_at;
  } vec_t;

  bfly_t rd_q[$];
  bfly_t wr_q[$];
  vec_t  tbl[11];
  int    vec_cnt  = 0;
  int    miss_cnt = 0;

  function automatic logic [63:0] outs();
    return {busy, done, err, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b};
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s @t+%0d: got %0d, expected %0d", name, i, act, exp);
    end
  endtask

  // Runs one stage and checks every cycle up to done+2. poke_at pulses start (while busy),
  // abort_at pulses abort, rst_at drops rst_n; each is applied in cycle t+<n> (0 = unused).
  task automatic run_stage(input int l, input int s, input int poke_at, input int abort_at,
                           input int rst_at, output int got_a, output int got_b,
                           output int got_tw, output int got_done);
    int    n_half, half, stride, last_i;
    bit    live, stop;
    bfly_t e;
    n_half = 1 << (l - 1);
    half   = 1 << s;
    stride = 1 << (l - 1 - s);
    rd_q.delete();
    wr_q.delete();
    for (int g = 0; g < n_half / half; g++) begin
      for (int p = 0; p < half; p++) begin
        e.a  = g * 2 * half + p;
        e.b  = e.a + half;
        e.tw = p * stride;
        rd_q.push_back(e);
        wr_q.push_back(e);
      end
    end
    got_a = -1; got_b = -1; got_tw = -1; got_done = -1;
    stop  = 1'b0;
    @(negedge clk);
    stage_number = 4'(l);
    stage_level  = 4'(s);
    start        = 1'b1;
    last_i = n_half + PIPE_LAT + 3;
    for (int i = 1; i <= last_i && !stop; i++) begin
      @(negedge clk);
      live = (abort_at == 0) || (i <= abort_at);
      chk("rd_en", i, 64'(rd_en), 64'(live && i <= n_half));
      chk("wr_en", i, 64'(wr_en), 64'(live && i > PIPE_LAT && i <= n_half + PIPE_LAT));
      chk("done",  i, 64'(done),  64'(live && i == n_half + PIPE_LAT + 1));
      chk("busy",  i, 64'(busy),  64'(live && i <= n_half + PIPE_LAT + 1));
      chk("err",   i, 64'(err),   64'd0);
      if (!live) chk("post_abort_zero", i, outs(), 64'd0);
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          vec_cnt++; miss_cnt++;
          $display("FAIL rd_extra @t+%0d: got read A=%0d, expected none", i, rd_addr_a);
        end else begin
          e = rd_q.pop_front();
          chk("rd_addr_a", i, 64'(rd_addr_a), 64'(e.a));
          chk("rd_addr_b", i, 64'(rd_addr_b), 64'(e.b));
          chk("tw_addr",   i, 64'(tw_addr),   64'(e.tw));
        end
        got_a  = int'(rd_addr_a);
        got_b  = int'(rd_addr_b);
        got_tw = int'(tw_addr);
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          vec_cnt++; miss_cnt++;
          $display("FAIL wr_extra @t+%0d: got write A=%0d, expected none", i, wr_addr_a);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr_a", i, 64'(wr_addr_a), 64'(e.a));
          chk("wr_addr_b", i, 64'(wr_addr_b), 64'(e.b));
        end
      end
      if (done) got_done = i;
      // Latched config must be used: scramble the live inputs once the stage has started
      start        = (i == poke_at);
      stage_level  = start ? 4'd0 : 4'hF;
      stage_number = start ? 4'd2 : 4'hF;
      abort        = (i == abort_at);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_zero", i, outs(), 64'd0);
        stop = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at == 0 && rst_at == 0) begin
      chk("rd_q_left", 0, 64'(rd_q.size()), 64'd0);
      chk("wr_q_left", 0, 64'(wr_q.size()), 64'd0);
    end
  endtask

  // Rejected start: err for exactly one cycle, nothing else moves
  task automatic run_err(input int l, input int s, output int got_err);
    @(negedge clk);
    stage_number = 4'(l);
    stage_level  = 4'(s);
    start        = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    got_err = int'(err);
    chk("err_busy", 1, 64'(busy),  64'd0);
    chk("err_rd",   1, 64'(rd_en), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("err_after_zero", i, outs(), 64'd0);
    end
  endtask

  initial begin
    int ga, gb, gt, gd, ge;
    //          L   s  err last_a last_b last_tw done
    tbl[0]  = '{ 3,  0, 0,    6,    7,    0,   12};
    tbl[1]  = '{ 3,  1, 0,    5,    7,    2,   12};
    tbl[2]  = '{ 3,  2, 0,    3,    7,    3,   12};
    tbl[3]  = '{12, 11, 0, 2047, 4095, 2047, 2056};
    tbl[4]  = '{ 1,  0, 0,    0,    1,    0,    9};
    tbl[5]  = '{ 4,  1, 0,   13,   15,    4,   16};
    tbl[6]  = '{ 6,  3, 0,   55,   63,   28,   40};
    tbl[7]  = '{ 3,  3, 1,    0,    0,    0,    0};
    tbl[8]  = '{ 0,  0, 1,    0,    0,    0,    0};
    tbl[9]  = '{13,  2, 1,    0,    0,    0,    0};
    tbl[10] = '{ 5,  7, 1,    0,    0,    0,    0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    stage_level = '0; stage_number = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 0, outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 0, outs(), 64'd0);

    for (int v = 0; v < 11; v++) begin
      if (tbl[v].exp_err) begin
        run_err(tbl[v].l, tbl[v].s, ge);
        chk("err_pulse", v, 64'(ge), 64'(tbl[v].exp_err));
      end else begin
        run_stage(tbl[v].l, tbl[v].s, 0, 0, 0, ga, gb, gt, gd);
        chk("last_rd_a",  v, 64'(ga), 64'(tbl[v].last_a));
        chk("last_rd_b",  v, 64'(gb), 64'(tbl[v].last_b));
        chk("last_tw",    v, 64'(gt), 64'(tbl[v].last_tw));
        chk("done_cycle", v, 64'(gd), 64'(tbl[v].done_at));
      end
    end

    // Start while busy: sequence unaffected
    run_stage(3, 1, 3, 0, 0, ga, gb, gt, gd);
    chk("busy_start_last_a", 0, 64'(ga), 64'd5);
    chk("busy_start_done",   0, 64'(gd), 64'd12);

    // Start coinciding with the done cycle: ignored (idle cycles after done are checked)
    run_stage(3, 0, 12, 0, 0, ga, gb, gt, gd);
    chk("done_start_done", 0, 64'(gd), 64'd12);

    // Abort during issue: outputs 0 next cycle, no write-back, no done
    run_stage(3, 0, 0, 3, 0, ga, gb, gt, gd);
    chk("abort_no_done", 0, 64'(gd), 64'(-1));

    // Abort together with start in IDLE: abort wins, valid or invalid config
    @(negedge clk);
    stage_number = 4'd3; stage_level = 4'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_1", 1, outs(), 64'd0);
    @(negedge clk);
    chk("abort_start_idle_2", 2, outs(), 64'd0);
    stage_number = 4'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_badcfg_no_err", 1, 64'(err), 64'd0);

    // Async reset mid-drain, then a clean stage afterwards
    run_stage(3, 0, 0, 0, 9, ga, gb, gt, gd);
    @(negedge clk);
    chk("held_in_reset", 0, outs(), 64'd0);
    rst_n = 1'b1;
    run_stage(3, 2, 0, 0, 0, ga, gb, gt, gd);
    chk("post_rst_last_a",  0, 64'(ga), 64'd3);
    chk("post_rst_last_b",  0, 64'(gb), 64'd7);
    chk("post_rst_last_tw", 0, 64'(gt), 64'd3);
    chk("post_rst_done",    0, 64'(gd), 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
